// File: rtl/sub_addsub_iter.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle through a registered carry.
// Valid/ready on both sides; the result and flags are held in DONE until accepted.
module sub_addsub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_neg,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [31:0]      lo;
  logic [CHUNK:0]   sum;
  logic             last;
  logic             accept;

  assign lo   = 32'(cnt_q) * 32'(CHUNK);
  assign sum  = {1'b0, a_q[lo +: CHUNK]}
              + {1'b0, b_q[lo +: CHUNK]}
              + {{CHUNK{1'b0}}, c_q};
  assign last = (cnt_q == CW'(NCHUNK - 1));

  assign in_ready = (state_q == IDLE)
                  | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && out_ready && !in_valid)
          state_d = IDLE;
        if (accept) begin
          // Subtraction is A + ~B + 1: invert B, seed the carry.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          c_d     = in_sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        r_d[lo +: CHUNK] = sum[CHUNK-1:0];
        c_d   = sum[CHUNK];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          res_d   = r_d;
          carry_d = sum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                  & (r_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (r_d == '0);
          neg_d   = r_d[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q == BUSY);
  assign out_res      = res_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;
  assign out_neg      = neg_q;

endmodule

// File: tb/tb_sub_addsub_iter.sv
// Bench for sub_addsub_iter: three configurations (32/8, 4/2, 8/8) each checked
// every cycle against a transaction-level model built on plain integer arithmetic.
module tb_sub_addsub_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input int cfg, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL cfg%0d %s: got %h want %h", cfg, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W  = (g == 0) ? 32 : (g == 1) ? 4 : 8;
    localparam int C  = (g == 0) ? 8 : (g == 1) ? 2 : 8;
    localparam int N  = W / C;
    localparam int NC = (g == 2) ? 30000 : 4000;

    typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
    } res_t;

    logic         rst = 1'b1;
    logic         iv = 1'b0, isub = 1'b0, ordy = 1'b0;
    logic [W-1:0] ia = '0, ib = '0;
    logic         ir, ov, oc, oo, oz, oneg, bz;
    logic [W-1:0] ores;
    bit           chk_en = 1'b0;
    bit           fin = 1'b0;

    sub_addsub_iter #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clock(clk), .reset(rst),
      .in_valid(iv), .in_ready(ir),
      .in_a(ia), .in_b(ib), .in_sub(isub),
      .out_valid(ov), .out_ready(ordy),
      .out_res(ores), .out_carry(oc),
      .out_overflow(oo), .out_zero(oz),
      .out_neg(oneg), .busy(bz)
    );

    function automatic res_t ref_op(input logic [W-1:0] a, b,
                                    input logic s);
      res_t   o;
      longint sa, sb, t, hi, lo;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = (longint'(1) <<< (W - 1)) - 1;
      lo = -(longint'(1) <<< (W - 1));
      if (s) begin
        o.r = a - b;
        o.c = (a >= b);
        t   = sa - sb;
      end else begin
        {o.c, o.r} = {1'b0, a} + {1'b0, b};
        t = sa + sb;
      end
      o.v = (t > hi) || (t < lo);
      o.z = (o.r == '0);
      o.n = o.r[W-1];
      return o;
    endfunction

    // Transaction model: 0 idle, 1 computing (m_left edges to go), 2 holding.
    int   m_mode = 0;
    int   m_left = 0;
    bit   m_valid = 1'b0;
    bit   m_fresh = 1'b1;
    res_t m_out = '0, m_pend = '0;

    initial forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_valid = 0; m_out = '0; m_fresh = 1;
      end else if (iv && (m_mode == 0 || (m_mode == 2 && ordy))) begin
        m_pend = ref_op(ia, ib, isub);
        m_mode = 1; m_left = N; m_valid = 0; m_fresh = 0;
      end else if (m_mode == 2 && ordy) begin
        m_mode = 0; m_valid = 0;
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 2; m_valid = 1; m_out = m_pend;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        chk(g, "out_valid", 64'(ov), 64'(m_valid));
        chk(g, "busy", 64'(bz), 64'(m_mode == 1));
        chk(g, "in_ready", 64'(ir),
            64'(m_mode == 0 || (m_mode == 2 && ordy)));
        if (m_valid || m_fresh)
          chk(g, "result", 64'(res_t'{r: ores, c: oc, v: oo, z: oz, n: oneg}),
              64'(m_out));
      end
    end

    task automatic run_op(input logic [W-1:0] a, b, input logic s,
                          input res_t lit);
      int lat;
      chk(g, "pin_model", 64'(ref_op(a, b, s)), 64'(lit));
      @(negedge clk);
      iv = 1; ia = a; ib = b; isub = s; ordy = 0;
      @(negedge clk);
      iv = 0; ia = ~a; ib = ~b; isub = ~s;
      lat = 0;
      while (!ov && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      chk(g, "latency", 64'(lat), 64'(N));
      chk(g, "pin_dut", 64'(res_t'{r: ores, c: oc, v: oo, z: oz, n: oneg}),
          64'(lit));
      repeat (5) @(negedge clk);
      chk(g, "hold_valid", 64'(ov), 64'(1));
      chk(g, "hold_ready", 64'(ir), 64'(0));
      ordy = 1;
      @(negedge clk);
      ordy = 0;
    endtask

    function automatic logic [W-1:0] pick();
      logic [W-1:0] mx;
      mx = {1'b0, {(W-1){1'b1}}};
      case ($urandom % 6)
        0: return '0;
        1: return mx;
        2: return ~mx;
        3: return '1;
        default: return W'($urandom);
      endcase
    endfunction

    initial begin
      logic [W-1:0] mx, mn, one, two, five;
      mx = {1'b0, {(W-1){1'b1}}};
      mn = ~mx;
      one = W'(1); two = W'(2); five = W'(5);
      repeat (2) @(negedge clk);
      chk_en = 1;
      rst = 0;
      run_op(two, '0, 1'b1, '{r: two, c: 1, v: 0, z: 0, n: 0});
      run_op('0, one, 1'b1, '{r: '1, c: 0, v: 0, z: 0, n: 1});
      run_op(mn, one, 1'b1, '{r: mx, c: 1, v: 1, z: 0, n: 0});
      run_op(mx, one, 1'b0, '{r: mn, c: 0, v: 1, z: 0, n: 1});
      run_op('1, one, 1'b0, '{r: '0, c: 1, v: 0, z: 1, n: 0});
      run_op(five, five, 1'b1, '{r: '0, c: 1, v: 0, z: 1, n: 0});
      // Back-to-back: accept a new op on the same edge the result leaves.
      @(negedge clk);
      iv = 1; ia = mx; ib = one; isub = 0;
      @(negedge clk);
      iv = 0;
      repeat (N + 5) @(negedge clk);
      iv = 1; ordy = 1; ia = two; ib = five; isub = 1;
      @(negedge clk);
      iv = 0; ordy = 0;
      chk(g, "b2b_busy", 64'(bz), 64'(1));
      // Reset while computing: nothing may come out afterwards.
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk(g, "rst_res", 64'(ores), 64'(0));
      chk(g, "rst_ready", 64'(ir), 64'(1));
      repeat (N + 3) @(negedge clk);
      chk(g, "rst_novalid", 64'(ov), 64'(0));
      repeat (NC) begin
        @(negedge clk);
        rst  = ($urandom % 200) == 0;
        iv   = ($urandom % 4) != 0;
        ordy = ($urandom % 4) != 0;
        ia   = pick();
        ib   = pick();
        isub = $urandom % 2;
      end
      @(negedge clk);
      rst = 0; iv = 0; ordy = 1;
      repeat (N + 3) @(negedge clk);
      fin = 1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && t < 90000) begin
      @(negedge clk);
      t++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      errs++;
      $display("FAIL timeout: got %0d cycles, want completion", t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
